// File: rtl/prbs_multi_gen.sv
// prbs_multi_gen
// Multi-lane PRBS pattern source with per-lane single-bit error injection.
// One shared LFSR (PRBS7/15/23/31, selected at reset/restart) produces WIDTH
// bits per clock. That word is fanned out to NCH lanes. Each lane can have a
// bit flipped on a one-shot or periodic event, and each lane keeps a
// saturating count of the errors injected into it.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   restart      pulse: reseed LFSR, relatch poly_sel, clear period counter
//   poly_sel     00 PRBS7, 01 PRBS15, 10 PRBS23, 11 PRBS31
//   inj_mode     bit0 one-shot enable, bit1 periodic enable
//   inj_trig     one-shot request pulse
//   inj_period   periodic interval in cycles (0 disables periodic)
//   inj_ch_mask  lanes that receive injections
//   inj_bit      bit index flipped (0 = LSB)
//   data_out     lane k at [k*WIDTH +: WIDTH]
//   data_valid   data_out holds a sequence word
//   inj_flag     lane k's current word carries an injected error
//   inj_count    lane k at [k*CNT_W +: CNT_W], saturating
module prbs_multi_gen #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     restart,
   input  logic [1:0]               poly_sel,
   input  logic [1:0]               inj_mode,
   input  logic                     inj_trig,
   input  logic [31:0]              inj_period,
   input  logic [NCH-1:0]           inj_ch_mask,
   input  logic [$clog2(WIDTH)-1:0] inj_bit,
   output logic [NCH*WIDTH-1:0]     data_out,
   output logic                     data_valid,
   output logic [NCH-1:0]           inj_flag,
   output logic [NCH*CNT_W-1:0]     inj_count
);

   // State bit 0 is the most recent sequence bit; bit k is k+1 bits back.
   // 31 bits cover the longest polynomial; shorter ones ignore the upper bits.
   localparam logic [30:0] SEED = '1;

   logic [30:0]      lfsr_reg;
   logic [30:0]      lfsr_next;
   logic [1:0]       poly_reg;
   logic [1:0]       poly_use;
   logic [30:0]      step_src;
   logic [WIDTH-1:0] word_next;
   logic             valid_reg;
   logic [31:0]      cnt_reg;
   logic [31:0]      cnt_next;
   logic             per_run;
   logic             per_hit;
   logic             one_hit;
   logic             inj_event;
   logic [WIDTH-1:0] flip_mask;

   // A restart produces the first word of the newly selected sequence in the
   // same edge, so the step starts from the seed with the incoming poly_sel.
   assign step_src = restart ? SEED : lfsr_reg;
   assign poly_use = restart ? poly_sel : poly_reg;

   // One unrolled WIDTH-bit step per polynomial; earliest bit lands in the MSB.
   for (genvar gi = 0; gi < 4; gi++) begin : g_poly
      localparam int N_TAP = (gi == 0) ? 7 : (gi == 1) ? 15 : (gi == 2) ? 23 : 31;
      localparam int M_TAP = (gi == 0) ? 6 : (gi == 1) ? 14 : (gi == 2) ? 18 : 28;
      logic [WIDTH-1:0] word;
      logic [30:0]      state;
      always_comb begin
         logic [30:0] s;
         logic        nb;
         s    = step_src;
         nb   = 1'b0;
         word = '0;
         for (int i = 0; i < WIDTH; i++) begin
            nb                = s[N_TAP-1] ^ s[M_TAP-1];
            word[WIDTH-1-i]   = nb;
            s                 = {s[29:0], nb};
         end
         state = s;
      end
   end

   always_comb begin
      word_next = g_poly[0].word;
      lfsr_next = g_poly[0].state;
      case (poly_use)
         2'd1: begin
            word_next = g_poly[1].word;
            lfsr_next = g_poly[1].state;
         end
         2'd2: begin
            word_next = g_poly[2].word;
            lfsr_next = g_poly[2].state;
         end
         2'd3: begin
            word_next = g_poly[3].word;
            lfsr_next = g_poly[3].state;
         end
         default: ;
      endcase
   end

   // Period counter: idles at 0 while periodic injection is off, so counting
   // always starts from 0. A shrink of inj_period below the current count
   // wraps it to 0 without an event (the >= compare covers that case).
   assign per_run   = inj_mode[1] && (inj_period != 32'd0);
   assign per_hit   = per_run && (cnt_reg == inj_period - 32'd1);
   assign one_hit   = inj_mode[0] && inj_trig;
   assign inj_event = !restart && (per_hit || one_hit);
   assign flip_mask = {{(WIDTH-1){1'b0}}, 1'b1} << inj_bit;

   always_comb begin
      cnt_next = cnt_reg + 32'd1;
      if (restart || !per_run || (cnt_reg >= inj_period - 32'd1)) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_reg  <= SEED;
         poly_reg  <= poly_sel;
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         lfsr_reg  <= lfsr_next;
         if (restart) begin
            poly_reg <= poly_sel;
         end
         cnt_reg   <= cnt_next;
         valid_reg <= 1'b1;
      end
   end

   assign data_valid = valid_reg;

   // Per-lane output word, flag and saturating injection count.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
      logic             hit;
      logic [WIDTH-1:0] data_reg;
      logic             flag_reg;
      logic [CNT_W-1:0] count_reg;

      assign hit = inj_event && inj_ch_mask[gi];

      always_ff @(posedge clk) begin
         if (reset) begin
            data_reg  <= '0;
            flag_reg  <= 1'b0;
            count_reg <= '0;
         end else begin
            data_reg <= word_next ^ (hit ? flip_mask : '0);
            flag_reg <= hit;
            if (hit && (count_reg != {CNT_W{1'b1}})) begin
               count_reg <= count_reg + 1'b1;
            end
         end
      end

      assign data_out[gi*WIDTH +: WIDTH]  = data_reg;
      assign inj_flag[gi]                 = flag_reg;
      assign inj_count[gi*CNT_W +: CNT_W] = count_reg;
   end

endmodule

// File: doc/prbs_multi_gen.md
# prbs_multi_gen

Parametrised multi-channel PRBS pattern source for the GBCR SEU/BER test firmware. One shared LFSR with run-time selectable polynomial (PRBS7/15/23/31) produces WIDTH bits per clock, fanned out to NCH channel lanes. Each lane can have single-bit errors injected one-shot or periodically, and keeps its own injected-error count. The downstream checker uses these counts to verify the bit-error rate it measures.

## Interface
- WIDTH, 32: bits per output word per channel (8..64).
- NCH, 4: channel lanes (1..8).
- CNT_W, 16: per-channel injection counter width.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- restart  in  1  pulse; reseeds the LFSR and clears the period counter (counts kept).
- poly_sel  in  2  00 PRBS7, 01 PRBS15, 10 PRBS23, 11 PRBS31.
- inj_mode  in  2  00 off, 01 one-shot, 10 periodic, 11 one-shot+periodic.
- inj_trig  in  1  one-shot request pulse.
- inj_period  in  32  periodic interval in clock cycles; 0 disables periodic.
- inj_ch_mask  in  NCH  lanes that receive injections.
- inj_bit  in  clog2(WIDTH)  bit index flipped; 0 = LSB.
- data_out  out  NCH*WIDTH  lane k at [k*WIDTH +: WIDTH].
- data_valid  out  1  data_out holds a sequence word.
- inj_flag  out  NCH  lane k's current word carries an injected error.
- inj_count  out  NCH*CNT_W  lane k at [k*CNT_W +: CNT_W].

## Operation
- Recursion: x[n] = x[n-N] ^ x[n-M], with (N,M) = (7,6), (15,14), (23,18), (31,28).
- LFSR state holds the last N sequence bits. Seed is all ones, loaded at reset and at restart.
- Each cycle, WIDTH new bits are generated. The earliest bit goes to the word MSB (WIDTH-1) and the latest to the LSB.
- The state then advances WIDTH bits. Implement as an unrolled combinational step, one per polynomial, muxed by poly_sel.
- poly_sel is sampled only in the reset or restart cycle. Changes at any other time have no effect.
- Every lane carries the same word before injection.
- Period counter runs whenever inj_mode[1]=1 and inj_period≠0. It counts 0..inj_period-1.
  - The count value inj_period-1 marks a periodic event, and the counter wraps to 0.
  - If inj_period changes to a value ≤ the current count, the counter wraps to 0 on the next cycle with no event.
- One-shot event: inj_trig=1 while inj_mode[0]=1.
- An event in cycle t causes the word output at t+1 to have bit inj_bit XORed on every lane with inj_ch_mask[k]=1.
  - That lane's inj_flag is 1 with the same word.
  - That lane's inj_count increments by 1, saturating at 2^CNT_W-1.
- A one-shot and a periodic event in the same cycle flip the bit once and count once.
- Masked-off lanes output the clean word, inj_flag=0, no count.
- restart has priority over injection in the same cycle: no event, and the period counter is cleared.

## Timing
- Reset values: data_out=0, data_valid=0, inj_flag=0, inj_count=0, period counter 0, LFSR = all ones, poly latched from poly_sel.
- First cycle after reset release: data_valid=1 and data_out holds the first sequence word.
- data_valid stays 1 until the next reset. A restart does not drop it: the word after the restart cycle is the first sequence word again.
- Latency: event to corrupted word is 1 cycle. The count update is visible in the same cycle as the flag.
- Reset mid-operation clears everything in the following cycle. Pending events are discarded.
- Periodic mode, inj_period=P: flagged words are exactly P cycles apart. The first flagged word appears P cycles after counting starts.
- inj_period=1: every word is flagged.

## Test plan
- PRBS31, WIDTH=32, reset release -> first word 0x0000000E on all lanes, data_valid=1. The stream matches the software model for 10^5 words, for each poly_sel value.
- One-shot: inj_mode=01, mask=4'b0101, inj_bit=0, one pulse -> next word has LSB flipped on lanes 0 and 2 only. inj_flag=4'b0101, and counts are 1,0,1,0.
- Periodic: inj_mode=10, inj_period=100, mask=all -> flags every 100 cycles. After 10,000 cycles each count is 100. Other bits match the model.
- Simultaneous: inj_mode=11, inj_period=5, trig coincident with the periodic event -> single flip, count +1.
- Saturation: CNT_W=4, inj_period=1 for 40 cycles -> counts stick at 15.
- restart in mid-stream with poly_sel changed to PRBS7 -> next word is the PRBS7 first word. Counts are kept and the period counter restarts at 0. A reset during periodic injection clears all outputs in the next cycle.
